// File: rtl/mdu_unit_pkg.sv
// Package for the multiply/divide unit.
// Contents: MDU opcode encodings, the MTHI/MTLO and MFHI/MFLO select codes
// shared with the control and bypass units, the FSM state type, and opcode
// classification helpers.
// Optional feature macro: MDU_MADD_EN adds MADD, MADDU, MSUB and MSUBU.
// When it is undefined those opcodes are treated as MDU_DUM.
package mdu_unit_pkg;

    localparam logic [3:0] MDU_DUM   = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MADD  = 4'd5;
    localparam logic [3:0] MDU_MADDU = 4'd6;
    localparam logic [3:0] MDU_MSUB  = 4'd7;
    localparam logic [3:0] MDU_MSUBU = 4'd8;

    localparam logic [1:0] MTHILO_MTHI = 2'b00;
    localparam logic [1:0] MTHILO_MTLO = 2'b01;
    localparam logic [1:0] MTHILO_NONE = 2'b10;

    localparam logic [1:0] MFHILO_NONE = 2'b00;
    localparam logic [1:0] MFHILO_MFHI = 2'b01;
    localparam logic [1:0] MFHILO_MFLO = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Opcodes that actually start the unit. Accumulate ops only count when
    // the feature is built in; otherwise they behave as MDU_DUM.
    function automatic logic is_valid_op(input logic [3:0] op);
        logic v;
        v = (op == MDU_MULT) || (op == MDU_MULTU) || is_div_op(op);
`ifdef MDU_MADD_EN
        v = v || (op == MDU_MADD) || (op == MDU_MADDU) ||
                 (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
        return v;
    endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// EX-stage bus between the pipeline and the multiply/divide unit.
// master: the EX stage (drives op, MT/MF selects and operands).
// slave : the MDU (drives busy, MF read data and the HI/LO registers).
// Handshake: there is no ready/valid pair; MDUOpE acts as a one-cycle valid
// that is only legal while MDUBusyE is low, and MDUBusyE is the stall the
// hazard unit applies to any following MDU or HI/LO instruction.
interface mdu_unit_if;
    logic [3:0]  MDUOpE;
    logic [1:0]  MTHILOE;
    logic [1:0]  MFHILOE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        MDUBusyE;
    logic [31:0] MDU_OutE;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output MDUOpE, MTHILOE, MFHILOE, SrcAE, SrcBE,
        input  MDUBusyE, MDU_OutE, HI, LO
    );

    modport slave (
        input  MDUOpE, MTHILOE, MFHILOE, SrcAE, SrcBE,
        output MDUBusyE, MDU_OutE, HI, LO
    );
endinterface

// File: rtl/mdu_div_core.sv
// Combinational signed/unsigned 32-bit divider.
// Ports: a (dividend), b (divisor), sign (1 = signed) -> q (quotient),
// r (remainder). Quotient truncates toward zero and the remainder takes the
// dividend's sign. Divide by zero gives q = all ones, r = a. Signed
// 0x80000000 / -1 gives q = 0x80000000, r = 0.
module mdu_div_core (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sign,
    output logic [31:0] q,
    output logic [31:0] r
);
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic        a_neg;
    logic        b_neg;

    assign a_neg = sign & a[31];
    assign b_neg = sign & b[31];
    assign a_mag = a_neg ? (~a + 32'd1) : a;
    assign b_mag = b_neg ? (~b + 32'd1) : b;

    always_comb begin
        q_mag = '0;
        r_mag = '0;
        q     = '0;
        r     = '0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sign && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            q     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
            r     = a_neg ? (~r_mag + 32'd1) : r_mag;
        end
    end
endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit for the EX stage; owns HI/LO.
// Ports: clk, reset (async, active high), bus (mdu_unit_if.slave: opcode,
// MT/MF selects, operands in; busy, MF read data, HI, LO out), state_dbg
// (current FSM state).
// Parameters: MUL_CYCLES / DIV_CYCLES (1..15) busy cycles per op class.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU, which
// accumulate into the {HI,LO} value present at completion.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_unit_if.slave  bus,
    output mdu_state_e state_dbg
);
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi_q, lo_q;
    logic        start;
    logic        done;
    logic [63:0] prod_s, prod_u, result;
    logic [31:0] div_q, div_r;

    assign start = is_valid_op(bus.MDUOpE) && (cnt_q == 4'd0);
    assign done  = (state_q == ST_RUN) && (cnt_q == 4'd1);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Operands are captured at start so forwarding changes during the
    // busy window cannot disturb the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            op_q  <= MDU_DUM;
            a_q   <= '0;
            b_q   <= '0;
        end else if (start) begin
            cnt_q <= is_div_op(bus.MDUOpE) ? DIV_LOAD : MUL_LOAD;
            op_q  <= bus.MDUOpE;
            a_q   <= bus.SrcAE;
            b_q   <= bus.SrcBE;
        end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    mdu_div_core u_div (
        .a    (a_q),
        .b    (b_q),
        .sign (op_q == MDU_DIV),
        .q    (div_q),
        .r    (div_r)
    );

    always_comb begin
        result = {hi_q, lo_q};
        case (op_q)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV,
            MDU_DIVU:  result = {div_r, div_q};
`ifdef MDU_MADD_EN
            MDU_MADD:  result = {hi_q, lo_q} + prod_s;
            MDU_MADDU: result = {hi_q, lo_q} + prod_u;
            MDU_MSUB:  result = {hi_q, lo_q} - prod_s;
            MDU_MSUBU: result = {hi_q, lo_q} - prod_u;
`endif
            default:   result = {hi_q, lo_q};
        endcase
    end

    // Completion has priority; MTHI/MTLO only land while the counter is idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (done) begin
            {hi_q, lo_q} <= result;
        end else if (cnt_q == 4'd0) begin
            if (bus.MTHILOE == MTHILO_MTHI) hi_q <= bus.SrcAE;
            if (bus.MTHILOE == MTHILO_MTLO) lo_q <= bus.SrcAE;
        end
    end

    assign bus.MDUBusyE = (cnt_q != 4'd0) || start;
    assign bus.MDU_OutE = (bus.MFHILOE == MFHILO_MFHI) ? hi_q :
                          (bus.MFHILOE == MFHILO_MFLO) ? lo_q : 32'd0;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_mdu_unit.sv
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_unit_if bus();
    mdu_state_e state_dbg;

    mdu_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          cycles;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // An op issued while the unit is running would be silently dropped.
    always @(posedge clk) begin
        if (!reset && state_dbg == ST_RUN && bus.MDUOpE != MDU_DUM) begin
            n_err++;
            $display("FAIL op_while_busy: got op %h expected %h", bus.MDUOpE, MDU_DUM);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic mt(input logic [1:0] sel, input logic [31:0] v);
        @(negedge clk);
        bus.MTHILOE = sel;
        bus.SrcAE   = v;
        @(negedge clk);
        bus.MTHILOE = MTHILO_NONE;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.MDUBusyE && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int cycles);
        int n;
        logic [63:0] e;
        @(negedge clk);
        bus.MDUOpE = op;
        bus.SrcAE  = a;
        bus.SrcBE  = b;
        exp_q.push_back(exp);
        #1 check({name, " start_busy"}, 64'(bus.MDUBusyE), 64'd1);
        @(negedge clk);
        bus.MDUOpE = MDU_DUM;
        bus.SrcAE  = $urandom;
        bus.SrcBE  = $urandom;
        wait_idle(n);
        check({name, " busy_cycles"}, 64'(n), 64'(cycles));
        e = exp_q.pop_front();
        check({name, " hilo"}, {bus.HI, bus.LO}, e);
        bus.MFHILOE = MFHILO_MFHI;
        #1 check({name, " mfhi"}, 64'(bus.MDU_OutE), 64'(e[63:32]));
        bus.MFHILOE = MFHILO_MFLO;
        #1 check({name, " mflo"}, 64'(bus.MDU_OutE), 64'(e[31:0]));
        bus.MFHILOE = MFHILO_NONE;
    endtask

    // ---------------- test ----------------
    initial begin
        int n;
        logic [31:0] ra, rb;

        vecs.push_back('{"mult_neg",   MDU_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, MUL_N});
        vecs.push_back('{"multu_max",  MDU_MULTU, 32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE, MUL_N});
        vecs.push_back('{"mult_big",   MDU_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, MUL_N});
        vecs.push_back('{"mult_min2",  MDU_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, MUL_N});
        vecs.push_back('{"div_neg",    MDU_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, DIV_N});
        vecs.push_back('{"div_negb",   MDU_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, DIV_N});
        vecs.push_back('{"div_both",   MDU_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0003, DIV_N});
        vecs.push_back('{"divu_zero",  MDU_DIVU,  32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, DIV_N});
        vecs.push_back('{"div_zero",   MDU_DIV,   32'hFFFF_FFF8, 32'd0,         64'hFFFF_FFF8_FFFF_FFFF, DIV_N});
        vecs.push_back('{"div_ovf",    MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DIV_N});
        vecs.push_back('{"divu_big",   MDU_DIVU,  32'hFFFF_FFFF, 32'd16,        64'h0000_000F_0FFF_FFFF, DIV_N});
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 1000);
            vecs.push_back('{"rand_multu", MDU_MULTU, ra, rb, {32'd0, ra} * {32'd0, rb}, MUL_N});
            vecs.push_back('{"rand_divu",  MDU_DIVU,  ra, rb, {ra % rb, ra / rb},        DIV_N});
        end

        reset       = 1'b1;
        bus.MDUOpE  = MDU_DUM;
        bus.MTHILOE = MTHILO_NONE;
        bus.MFHILOE = MFHILO_MFHI;
        bus.SrcAE   = '0;
        bus.SrcBE   = '0;
        #1;
        check("reset busy", 64'(bus.MDUBusyE), 64'd0);
        check("reset hilo", {bus.HI, bus.LO}, 64'd0);
        check("reset out",  64'(bus.MDU_OutE), 64'd0);
        bus.MFHILOE = MFHILO_NONE;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].cycles);

        // MTLO then MFLO on the following cycle
        mt(MTHILO_MTLO, 32'h0000_1234);
        bus.MFHILOE = MFHILO_MFLO;
        #1 check("mtlo mflo", 64'(bus.MDU_OutE), 64'h1234);
        bus.MFHILOE = MFHILO_NONE;
        #1 check("mf none", 64'(bus.MDU_OutE), 64'd0);

        // MTHI mid-DIV is dropped and the DIV result still lands
        mt(MTHILO_MTHI, 32'h0000_0055);
        @(negedge clk);
        bus.MDUOpE = MDU_DIV;
        bus.SrcAE  = 32'd100;
        bus.SrcBE  = 32'd7;
        @(negedge clk);
        bus.MDUOpE = MDU_DUM;
        repeat (2) @(negedge clk);
        bus.MTHILOE = MTHILO_MTHI;
        bus.SrcAE   = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.MTHILOE = MTHILO_NONE;
        check("mthi busy ignored", 64'(bus.HI), 64'h55);
        wait_idle(n);
        check("mthi div result", {bus.HI, bus.LO}, {32'd2, 32'd14});

        // Reset in the middle of a MULT aborts it
        @(negedge clk);
        bus.MDUOpE = MDU_MULT;
        bus.SrcAE  = 32'd5;
        bus.SrcBE  = 32'd6;
        @(negedge clk);
        bus.MDUOpE = MDU_DUM;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort busy", 64'(bus.MDUBusyE), 64'd0);
        check("abort hilo", {bus.HI, bus.LO}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (MUL_N) @(negedge clk);
        check("abort no late write", {bus.HI, bus.LO}, 64'd0);
        run_op("mult_after_reset", MDU_MULT, 32'd2, 32'd3, 64'd6, MUL_N);

        // Accumulate ops
        mt(MTHILO_MTHI, 32'd0);
        mt(MTHILO_MTLO, 32'd10);
`ifdef MDU_MADD_EN
        run_op("madd", MDU_MADD, 32'd4, 32'd5, 64'h1E, MUL_N);
        run_op("msub", MDU_MSUB, 32'd2, 32'd3, 64'h18, MUL_N);
`else
        @(negedge clk);
        bus.MDUOpE = MDU_MADD;
        bus.SrcAE  = 32'd4;
        bus.SrcBE  = 32'd5;
        #1 check("madd off busy", 64'(bus.MDUBusyE), 64'd0);
        @(negedge clk);
        bus.MDUOpE = MDU_DUM;
        check("madd off busy2", 64'(bus.MDUBusyE), 64'd0);
        repeat (MUL_N + 1) @(negedge clk);
        check("madd off hilo", {bus.HI, bus.LO}, 64'd10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
